// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory front end below the CPU datapath.
// Serialises instruction fetches and data loads/stores onto one
// request/grant/response bus. Data requests win over fetches.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to enable the
// TIMEOUT_CYCLES cycle watchdog and the bus_err pulse.
//
// Bus handshake: bus_req is held high with stable bus_we/addr/wdata/be
// until a cycle with bus_gnt=1 (request accepted on that rising edge);
// exactly one later cycle with bus_rvalid=1 completes it (read data or
// write acknowledge). bus_gnt outside *_REQ and bus_rvalid outside
// *_RSP are ignored.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_ren,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_load,
    output logic        ihit,
    input  logic        dmem_ren,
    input  logic        dmem_wen,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_store,
    input  logic [2:0]  dmem_width,
    output logic [31:0] dmem_load,
    output logic        dhit,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    typedef enum logic [2:0] {IDLE, D_REQ, D_RSP, I_REQ, I_RSP} state_t;

    state_t      state;
    logic [31:0] cap_addr;      // full byte address of the request in flight
    logic [1:0]  off_d;
    logic [3:0]  mask_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] load_shifted;
    logic        fetch_match;
    logic        wd_fire;
    logic        unused_width;

    // Width bit 2 carries no meaning for this block.
    assign unused_width = dmem_width[2];

    // Lane steering for the incoming data request and the returning load.
    always_comb begin
        off_d = dmem_addr[1:0];
        case (dmem_width[1:0])
            2'b00:   mask_d = 4'b0001;
            2'b01:   mask_d = 4'b0011;
            default: mask_d = 4'b1111;
        endcase
        // Lanes shifted past byte 3 fall off the 4-bit result.
        be_d         = mask_d << off_d;
        wdata_d      = dmem_store << {off_d, 3'b000};
        load_shifted = bus_rdata >> {cap_addr[1:0], 3'b000};
        // A fetch result is only delivered if the datapath still wants it.
        fetch_match  = imem_ren && (imem_addr == cap_addr);
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = 16;
    logic [CNT_W-1:0] wd_cnt;

    // Fires in the TIMEOUT_CYCLES-th cycle spent in one busy state.
    assign wd_fire = (state != IDLE) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout;

    // No watchdog: the parameter is only referenced to keep one interface.
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign wd_fire        = 1'b0;
    assign bus_err        = 1'b0;
`endif

    // Arbitration FSM with all bus and datapath outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cap_addr  <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            imem_load <= '0;
            dmem_load <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            bus_err   <= 1'b0;
            wd_cnt    <= '0;
`endif
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            bus_err <= 1'b0;
            wd_cnt  <= wd_cnt + 1'b1;
`endif
            case (state)
                IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    // The hit cycle is skipped so a request the datapath is
                    // still holding while it sees its hit is not reissued.
                    if (!(ihit || dhit)) begin
                        if (dmem_ren || dmem_wen) begin
                            state     <= D_REQ;
                            cap_addr  <= dmem_addr;
                            bus_req   <= 1'b1;
                            bus_we    <= dmem_wen;
                            bus_addr  <= {dmem_addr[31:2], 2'b00};
                            bus_wdata <= wdata_d;
                            bus_be    <= be_d;
                        end else if (imem_ren) begin
                            state     <= I_REQ;
                            cap_addr  <= imem_addr;
                            bus_req   <= 1'b1;
                            bus_we    <= 1'b0;
                            bus_addr  <= {imem_addr[31:2], 2'b00};
                            bus_wdata <= '0;
                            bus_be    <= 4'b1111;
                        end
                    end
                end
                D_REQ, I_REQ: begin
                    if (bus_gnt) begin
                        state   <= (state == D_REQ) ? D_RSP : I_RSP;
                        bus_req <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                        wd_cnt  <= '0;
`endif
                    end
                end
                D_RSP: begin
                    if (bus_rvalid) begin
                        state <= IDLE;
                        dhit  <= 1'b1;
                        // Stores leave the last load value in place.
                        if (!bus_we) begin
                            dmem_load <= load_shifted;
                        end
                    end
                end
                I_RSP: begin
                    if (bus_rvalid) begin
                        state <= IDLE;
                        // A redirected fetch is dropped without a hit.
                        if (fetch_match) begin
                            ihit      <= 1'b1;
                            imem_load <= bus_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef MEM_ARB_TIMEOUT_EN
            // Watchdog abort completes the pending request with a marker value.
            if (wd_fire) begin
                state   <= IDLE;
                bus_req <= 1'b0;
                bus_err <= 1'b1;
                wd_cnt  <= '0;
                if (state == D_REQ || state == D_RSP) begin
                    dhit      <= 1'b1;
                    dmem_load <= 32'hDEADBEEF;
                end else if (fetch_match) begin
                    ihit      <= 1'b1;
                    imem_load <= 32'hDEADBEEF;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven data-path vectors, directed multi-cycle
// sequences, then randomized traffic against a byte-level memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic [31:0] imem_load;
    logic        ihit;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_store;
    logic [2:0]  dmem_width;
    logic [31:0] dmem_load;
    logic        dhit;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    // Bus inputs come either from directed sequences or the auto responder.
    logic        auto_bus = 1'b0;
    logic        d_gnt = 1'b0, d_rvalid = 1'b0;
    logic [31:0] d_rdata = '0;
    logic        s_gnt = 1'b0, s_rvalid = 1'b0;
    logic [31:0] s_rdata = '0;

    assign bus_gnt    = auto_bus ? s_gnt    : d_gnt;
    assign bus_rvalid = auto_bus ? s_rvalid : d_rvalid;
    assign bus_rdata  = auto_bus ? s_rdata  : d_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .imem_ren(imem_ren), .imem_addr(imem_addr), .imem_load(imem_load), .ihit(ihit),
        .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
        .dmem_store(dmem_store), .dmem_width(dmem_width), .dmem_load(dmem_load), .dhit(dhit),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .bus_err(bus_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // ---------------- reference memory model ----------------
    logic [7:0]  rmem[logic [31:0]];    // byte address -> byte
    logic [31:0] smem[logic [31:0]];    // responder storage, word address -> word

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h0007};
    endfunction

    function automatic logic [7:0] rbyte(input logic [31:0] a);
        logic [31:0] w;
        if (rmem.exists(a)) return rmem[a];
        w = init_word({a[31:2], 2'b00});
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a);
        logic [31:0] v = '0;
        int off = int'(a[1:0]);
        for (int k = 0; k < 4 - off; k++) v[8*k +: 8] = rbyte(a + 32'(k));
        return v;
    endfunction

    function automatic logic [31:0] ref_fetch(input logic [31:0] a);
        logic [31:0] v;
        for (int k = 0; k < 4; k++) v[8*k +: 8] = rbyte({a[31:2], 2'b00} + 32'(k));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [2:0] w, input logic [31:0] d);
        int n   = (w[1:0] == 2'b00) ? 1 : (w[1:0] == 2'b01) ? 2 : 4;
        int off = int'(a[1:0]);
        for (int k = 0; k < n; k++)
            if (off + k < 4) rmem[a + 32'(k)] = d[8*k +: 8];
    endtask

    // ---------------- auto bus responder ----------------
    int          sp = 0;
    int          sdly = 0;
    logic        c_we;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;

    initial begin
        forever begin
            tick();
            s_gnt    = 1'b0;
            s_rvalid = 1'b0;
            if (auto_bus) begin
                if (sp == 0) begin
                    if (bus_req) begin
                        if (sdly == 0) begin
                            s_gnt   = 1'b1;
                            c_we    = bus_we;
                            c_addr  = bus_addr;
                            c_be    = bus_be;
                            c_wdata = bus_wdata;
                            sp      = 1;
                            sdly    = $urandom_range(0, 3);
                        end else sdly--;
                    end
                end else if (sdly == 0) begin
                    logic [31:0] w;
                    w = smem.exists(c_addr) ? smem[c_addr] : init_word(c_addr);
                    if (c_we) begin
                        for (int l = 0; l < 4; l++)
                            if (c_be[l]) w[8*l +: 8] = c_wdata[8*l +: 8];
                        smem[c_addr] = w;
                        s_rdata = $urandom();
                    end else s_rdata = w;
                    s_rvalid = 1'b1;
                    sp       = 0;
                    sdly     = $urandom_range(0, 3);
                end else sdly--;
            end
        end
    end

    // ---------------- table-driven data vectors ----------------
    typedef struct {
        logic        we;
        logic [2:0]  width;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vecs[9];

    task automatic do_vec(input vec_t v);
        dmem_ren = !v.we; dmem_wen = v.we; dmem_addr = v.addr;
        dmem_store = v.store; dmem_width = v.width;
        tick();
        chk("vec_bus_req", bus_req, 1);
        chk("vec_bus_we", bus_we, v.we);
        chk("vec_bus_addr", bus_addr, v.exp_addr);
        chk("vec_bus_be", bus_be, v.exp_be);
        if (v.we) chk("vec_bus_wdata", bus_wdata, v.exp_wdata);
        d_gnt = 1'b1;
        tick();
        d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = v.rdata;
        chk("vec_req_dropped", bus_req, 0);
        tick();
        d_rvalid = 1'b0;
        chk("vec_dhit", dhit, 1);
        if (!v.we) chk("vec_dmem_load", dmem_load, v.exp_load);
        dmem_ren = 1'b0; dmem_wen = 1'b0;
        tick();
        chk("vec_dhit_pulse", dhit, 0);
    endtask

    // ---------------- random transaction driver ----------------
    logic [32:0] exp_dq[$];    // {is_load, expected load}
    logic [31:0] exp_iq[$];
    bit          rand_abort = 0;

    task automatic rand_txn();
        int          kind = $urandom_range(0, 2);
        logic        dp = (kind != 0);
        logic        ip = (kind != 1);
        logic [31:0] da = 32'h8000 + 32'($urandom_range(0, 31));
        logic [31:0] ia = 32'h8000 + 32'($urandom_range(0, 31));
        logic [2:0]  w  = 3'($urandom_range(0, 7));
        logic        we = 1'($urandom_range(0, 1));
        logic [31:0] st = $urandom();
        logic [32:0] e;
        int          cyc = 0;
        // Data is serviced before the fetch, so its effect is modelled first.
        if (dp) begin
            if (we) begin
                ref_store(da, w, st);
                exp_dq.push_back({1'b0, 32'h0});
            end else exp_dq.push_back({1'b1, ref_load(da)});
            dmem_ren = !we; dmem_wen = we; dmem_addr = da; dmem_store = st; dmem_width = w;
        end
        if (ip) begin
            exp_iq.push_back(ref_fetch(ia));
            imem_ren = 1'b1; imem_addr = ia;
        end
        while ((dp || ip) && cyc < 100) begin
            tick();
            cyc++;
            if (dhit) begin
                if (!dp || exp_dq.size() == 0) fail_now("rand_dhit_unexpected");
                else begin
                    e = exp_dq.pop_front();
                    if (e[32]) chk("rand_dmem_load", dmem_load, e[31:0]);
                    dp = 1'b0; dmem_ren = 1'b0; dmem_wen = 1'b0;
                end
            end
            if (ihit) begin
                if (!ip || dp || exp_iq.size() == 0) fail_now("rand_ihit_order");
                else begin
                    chk("rand_imem_load", imem_load, exp_iq.pop_front());
                    ip = 1'b0; imem_ren = 1'b0;
                end
            end
        end
        if (dp || ip) begin
            fail_now("rand_hit_timeout");
            rand_abort = 1;
            dmem_ren = 1'b0; dmem_wen = 1'b0; imem_ren = 1'b0;
        end
        tick();
    endtask

    // ---------------- main sequence ----------------
    bit got;

    initial begin
        vecs[0] = '{1'b1, 3'b000, 32'h1003, 32'h000000AB, 32'h0,        32'h1000, 4'b1000, 32'hAB000000, 32'h0};
        vecs[1] = '{1'b0, 3'b001, 32'h1002, 32'h0,        32'hBEEF1234, 32'h1000, 4'b1100, 32'h0,        32'h0000BEEF};
        vecs[2] = '{1'b1, 3'b001, 32'h2001, 32'h00001236, 32'h0,        32'h2000, 4'b0110, 32'h00123600, 32'h0};
        vecs[3] = '{1'b1, 3'b010, 32'h3002, 32'hCAFEBABE, 32'h0,        32'h3000, 4'b1100, 32'hBABE0000, 32'h0};
        vecs[4] = '{1'b0, 3'b000, 32'h4001, 32'h0,        32'h11223344, 32'h4000, 4'b0010, 32'h0,        32'h00112233};
        vecs[5] = '{1'b0, 3'b011, 32'h5000, 32'h0,        32'h89ABCDEF, 32'h5000, 4'b1111, 32'h0,        32'h89ABCDEF};
        vecs[6] = '{1'b1, 3'b100, 32'h6002, 32'h77777755, 32'h0,        32'h6000, 4'b0100, 32'h77550000, 32'h0};
        vecs[7] = '{1'b0, 3'b010, 32'h7003, 32'h0,        32'hA1B2C3D4, 32'h7000, 4'b1000, 32'h0,        32'h000000A1};
        vecs[8] = '{1'b1, 3'b001, 32'h2003, 32'h00001236, 32'h0,        32'h2000, 4'b1000, 32'h36000000, 32'h0};

        rst = 1'b1;
        imem_ren = 1'b0; imem_addr = '0;
        dmem_ren = 1'b0; dmem_wen = 1'b0; dmem_addr = '0; dmem_store = '0; dmem_width = '0;
        repeat (3) tick();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_hits", {ihit, dhit, bus_err}, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_imem_load", imem_load, 0);
        chk("rst_dmem_load", dmem_load, 0);
        rst = 1'b0;

        // Fetch with immediate grant: hit three cycles after the request edge.
        imem_ren = 1'b1; imem_addr = 32'h100;
        tick();
        chk("fetch_bus_req", bus_req, 1);
        chk("fetch_bus_addr", bus_addr, 32'h100);
        chk("fetch_bus_be", bus_be, 4'b1111);
        chk("fetch_bus_we", bus_we, 0);
        d_gnt = 1'b1;
        tick();
        d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = 32'h00000013;
        chk("fetch_no_early_hit", ihit, 0);
        tick();
        d_rvalid = 1'b0;
        chk("fetch_ihit", ihit, 1);
        chk("fetch_imem_load", imem_load, 32'h00000013);
        imem_ren = 1'b0;
        tick();
        chk("fetch_ihit_pulse", ihit, 0);
        chk("fetch_load_held", imem_load, 32'h00000013);

        foreach (vecs[i]) do_vec(vecs[i]);

        // Simultaneous fetch and load: data goes first.
        imem_ren = 1'b1; imem_addr = 32'h200;
        dmem_ren = 1'b1; dmem_addr = 32'h1000; dmem_width = 3'b010;
        tick();
        chk("prio_bus_addr_data", bus_addr, 32'h1000);
        d_gnt = 1'b1;
        tick();
        d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = 32'h0BADF00D;
        tick();
        d_rvalid = 1'b0;
        chk("prio_dhit", dhit, 1);
        chk("prio_no_ihit", ihit, 0);
        chk("prio_dmem_load", dmem_load, 32'h0BADF00D);
        dmem_ren = 1'b0;
        tick();
        chk("prio_idle_gap", bus_req, 0);
        tick();
        chk("prio_fetch_req", bus_req, 1);
        chk("prio_fetch_addr", bus_addr, 32'h200);
        d_gnt = 1'b1;
        tick();
        d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = 32'h00000093;
        tick();
        d_rvalid = 1'b0;
        chk("prio_ihit", ihit, 1);
        chk("prio_imem_load", imem_load, 32'h00000093);
        imem_ren = 1'b0;
        tick();

        // Redirect during I_RSP: stale fetch discarded, new address fetched.
        imem_ren = 1'b1; imem_addr = 32'h300;
        tick();
        chk("redir_bus_addr", bus_addr, 32'h300);
        d_gnt = 1'b1;
        tick();
        d_gnt = 1'b0; imem_addr = 32'h400;
        tick();
        d_rvalid = 1'b1; d_rdata = 32'h33333333;
        tick();
        d_rvalid = 1'b0;
        chk("redir_no_ihit", ihit, 0);
        chk("redir_load_kept", imem_load, 32'h00000093);
        tick();
        chk("redir_new_req", bus_req, 1);
        chk("redir_new_addr", bus_addr, 32'h400);
        d_gnt = 1'b1;
        tick();
        d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = 32'h44444444;
        tick();
        d_rvalid = 1'b0;
        chk("redir_ihit", ihit, 1);
        chk("redir_imem_load", imem_load, 32'h44444444);
        imem_ren = 1'b0;
        tick();

        // Reset during D_RSP, then a late response.
        dmem_ren = 1'b1; dmem_addr = 32'h1000; dmem_width = 3'b010;
        tick();
        d_gnt = 1'b1;
        tick();
        d_gnt = 1'b0; rst = 1'b1; dmem_ren = 1'b0;
        tick();
        rst = 1'b0; d_rvalid = 1'b1; d_rdata = 32'h12121212;
        chk("rstmid_bus_req", bus_req, 0);
        chk("rstmid_no_dhit", dhit, 0);
        tick();
        d_rvalid = 1'b0;
        chk("rstmid_late_rsp_ignored", dhit, 0);
        chk("rstmid_still_idle", bus_req, 0);
        chk("rstmid_dmem_load", dmem_load, 0);
        tick();

        // Stray grant/response while idle.
        d_gnt = 1'b1; d_rvalid = 1'b1; d_rdata = 32'hFFFFFFFF;
        tick();
        d_gnt = 1'b0; d_rvalid = 1'b0;
        chk("stray_no_req", bus_req, 0);
        chk("stray_no_hits", {ihit, dhit}, 0);
        tick();
        chk("stray_no_hits_later", {ihit, dhit}, 0);

        // Request held through the cycle after its hit is a new request.
        dmem_ren = 1'b1; dmem_addr = 32'h1004; dmem_width = 3'b010;
        tick();
        d_gnt = 1'b1;
        tick();
        d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = 32'h00000005;
        tick();
        d_rvalid = 1'b0;
        chk("held_dhit", dhit, 1);
        tick();
        chk("held_gap", bus_req, 0);
        chk("held_dhit_pulse", dhit, 0);
        tick();
        chk("held_reissue", bus_req, 1);
        dmem_ren = 1'b0; d_gnt = 1'b1;
        tick();
        d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = 32'h00000006;
        tick();
        d_rvalid = 1'b0;
        chk("held_second_dhit", dhit, 1);
        chk("held_second_load", dmem_load, 32'h00000006);
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Grant never arrives: watchdog completes the load with the marker.
        dmem_ren = 1'b1; dmem_addr = 32'h1000; dmem_width = 3'b010;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (dhit) got = 1;
        end
        if (!got) fail_now("timeout_dhit");
        else begin
            chk("timeout_bus_err", bus_err, 1);
            chk("timeout_dmem_load", dmem_load, 32'hDEADBEEF);
        end
        dmem_ren = 1'b0;
        tick();
        chk("timeout_err_pulse", bus_err, 0);
        chk("timeout_idle", bus_req, 0);
        tick();
`endif

        // Randomized traffic with random grant/response delays.
        auto_bus = 1'b1;
        for (int t = 0; t < 300 && !rand_abort; t++) rand_txn();
        auto_bus = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
